pb_input_device: RTL and testbench

//  Memory-mapped responder for the four user push-buttons (user_pb[4:1], active-low) on the bridge device bus.
//  - Synchronises and debounces each button.
//  - Latches press events into a sticky pending register.
//  - Counts presses.
//  - Raises a level interrupt into one HWInt line through the bridge.
//  - CPU reads and writes it through dev_addr / dev_wd / a per-device write enable, like the timer and UART.

---
 rtl/pb_input_device_pkg.sv | 17 +
 rtl/pb_debounce.sv | 53 +++++
 rtl/pb_input_device.sv | 92 +++++++++
 tb/tb_pb_input_device.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pb_input_device_pkg.sv
// Shared definitions for the push-button input device.
// Contents: the register offsets, the number of buttons, and a popcount helper
// that sums one edge's press events.
package pb_input_device_pkg;

    localparam int unsigned PB_NUM = 4;

    localparam logic [1:0] PB_REG_STATE   = 2'd0;
    localparam logic [1:0] PB_REG_PENDING = 2'd1;
    localparam logic [1:0] PB_REG_MASK    = 2'd2;
    localparam logic [1:0] PB_REG_COUNT   = 2'd3;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// Debouncer for one button, with synchroniser and press detection.
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   raw_n   in  raw button pin, active-low, asynchronous to clk
//   stable  out debounced level (1 = pressed)
//   press   out 1 on the edge where stable goes 0->1 (combinational)
// The synchroniser adds 2 cycles. The counter then needs DEBOUNCE_CYCLES edges
// with a mismatch, so a clean edge takes 2 + DEBOUNCE_CYCLES cycles to appear.
module pb_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned CNT_W           = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic stable,
    output logic press
);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mismatch;
    logic             flip;

    assign mismatch = sync2_q != stable_q;
    // Flip only if the mismatch is still present on the final counting edge.
    assign flip     = mismatch && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign stable   = stable_q;
    assign press    = flip && !stable_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= ~raw_n;
            sync2_q <= sync1_q;
            if (!mismatch || flip) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (flip) begin
                stable_q <= ~stable_q;
            end
        end
    end

endmodule

// File: rtl/pb_input_device.sv
// Memory-mapped responder for the four active-low user push-buttons.
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   user_pb  in   raw button pins [4:1], active-low
//   ADD_I    in   register select (dev_addr[3:2])
//   WE_I     in   single-cycle write strobe
//   DAT_I    in   write data
//   DAT_O    out  read data, combinational from registers
//   IRQ      out  level interrupt = |(pending & mask)
// Register map: 0 STATE (RO), 1 PENDING (W1C), 2 MASK (RW), 3 COUNT (write clears).
module pb_input_device
    import pb_input_device_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned CNT_W           = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:1]  user_pb,
    input  logic [1:0]  ADD_I,
    input  logic        WE_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        IRQ
);

    logic [PB_NUM-1:0] stable;
    logic [PB_NUM-1:0] press;
    logic [PB_NUM-1:0] pending_q, pending_d;
    logic [PB_NUM-1:0] mask_q, mask_d;
    logic [15:0]       count_q, count_d;
    logic              unused_dat;

    assign unused_dat = ^DAT_I[31:4];

    for (genvar i = 0; i < PB_NUM; i++) begin : g_btn
        pb_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .raw_n  (user_pb[i+1]),
            .stable (stable[i]),
            .press  (press[i])
        );
    end

    always_comb begin
        pending_d = pending_q;
        mask_d    = mask_q;
        count_d   = count_q;
        if (WE_I && ADD_I == PB_REG_PENDING) begin
            pending_d = pending_q & ~DAT_I[PB_NUM-1:0];
        end
        // Set after the clear so a same-edge press keeps its pending bit.
        pending_d = pending_d | press;
        if (WE_I && ADD_I == PB_REG_MASK) begin
            mask_d = DAT_I[PB_NUM-1:0];
        end
        if (WE_I && ADD_I == PB_REG_COUNT) begin
            count_d = '0;
        end
        count_d = count_d + 16'(popcount4(press));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            mask_q    <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        DAT_O = '0;
        case (ADD_I)
            PB_REG_STATE:   DAT_O = {28'b0, stable};
            PB_REG_PENDING: DAT_O = {28'b0, pending_q};
            PB_REG_MASK:    DAT_O = {28'b0, mask_q};
            PB_REG_COUNT:   DAT_O = {16'b0, count_q};
            default:        DAT_O = '0;
        endcase
    end

    assign IRQ = |(pending_q & mask_q);

endmodule

// File: tb/tb_pb_input_device.sv
module tb_pb_input_device;

    localparam logic [1:0] RS = 2'd0;
    localparam logic [1:0] RP = 2'd1;
    localparam logic [1:0] RM = 2'd2;
    localparam logic [1:0] RC = 2'd3;

    logic        clk;
    logic        rst;
    logic [4:1]  user_pb;
    logic [1:0]  ADD_I;
    logic        WE_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        IRQ;

    int n_cmp = 0;
    int n_bad = 0;

    pb_input_device #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .user_pb (user_pb),
        .ADD_I   (ADD_I),
        .WE_I    (WE_I),
        .DAT_I   (DAT_I),
        .DAT_O   (DAT_O),
        .IRQ     (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        stop;
        logic [3:0]  pb;
        logic        we;
        logic [1:0]  waddr;
        logic [31:0] wd;
        logic [7:0]  cycles;
        logic [1:0]  raddr;
        logic [31:0] exp_dat;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];
    int   vptr = 0;

    task automatic add(input logic [3:0] pb, input logic we, input logic [1:0] waddr,
                       input logic [31:0] wd, input int cyc, input logic [1:0] raddr,
                       input logic [31:0] exp_dat, input logic exp_irq);
        vec_t v;
        v.stop = 1'b0; v.pb = pb; v.we = we; v.waddr = waddr; v.wd = wd;
        v.cycles = 8'(cyc); v.raddr = raddr; v.exp_dat = exp_dat; v.exp_irq = exp_irq;
        vecs.push_back(v);
    endtask

    task automatic add_stop();
        vec_t v;
        v = '0;
        v.stop = 1'b1;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic chk_reg(input string name, input logic [1:0] addr, input logic [31:0] exp);
        ADD_I = addr;
        #1;
        cmp(name, DAT_O, exp);
    endtask

    // Applies table entries until the next stop marker.
    task automatic run_vecs();
        vec_t v;
        while (vptr < vecs.size()) begin
            v = vecs[vptr];
            if (v.stop) begin
                vptr++;
                return;
            end
            user_pb = v.pb;
            if (v.we) begin
                ADD_I = v.waddr;
                DAT_I = v.wd;
                WE_I  = 1'b1;
            end
            for (int c = 0; c < int'(v.cycles); c++) begin
                tick();
                WE_I = 1'b0;
            end
            WE_I  = 1'b0;
            ADD_I = v.raddr;
            #1;
            cmp($sformatf("vec%0d_dat", vptr), DAT_O, v.exp_dat);
            cmp($sformatf("vec%0d_irq", vptr), {31'b0, IRQ}, {31'b0, v.exp_irq});
            vptr++;
        end
    endtask

    initial begin
        // Reset state
        add(4'b1111, 0, RS, 0, 0, RS, 32'h0, 0);
        add(4'b1111, 0, RS, 0, 0, RP, 32'h0, 0);
        add(4'b1111, 0, RS, 0, 0, RM, 32'h0, 0);
        add(4'b1111, 0, RS, 0, 0, RC, 32'h0, 0);
        add_stop();
        // Button 1 held: pending and count, then unmask
        add(4'b1110, 0, RS, 0, 0, RP, 32'h1, 0);
        add(4'b1110, 0, RS, 0, 0, RC, 32'h1, 0);
        add(4'b1110, 1, RM, 32'hF, 1, RM, 32'hF, 1);
        add(4'b1110, 0, RS, 0, 0, RS, 32'h1, 1);
        // 3-cycle glitch on button 2 is rejected
        add(4'b1100, 0, RS, 0, 3, RS, 32'h1, 1);
        add(4'b1110, 0, RS, 0, 6, RS, 32'h1, 1);
        add(4'b1110, 0, RS, 0, 0, RP, 32'h1, 1);
        add(4'b1110, 0, RS, 0, 0, RC, 32'h1, 1);
        // 4-cycle low on button 2 is accepted
        add(4'b1100, 0, RS, 0, 4, RS, 32'h1, 1);
        add(4'b1110, 0, RS, 0, 2, RS, 32'h3, 1);
        add(4'b1110, 0, RS, 0, 0, RP, 32'h3, 1);
        add(4'b1110, 0, RS, 0, 0, RC, 32'h2, 1);
        add(4'b1111, 0, RS, 0, 8, RS, 32'h0, 1);
        add(4'b1111, 0, RS, 0, 0, RP, 32'h3, 1);
        // W1C racing a new press of button 1
        add(4'b1111, 1, RP, 32'h3, 1, RP, 32'h0, 0);
        add(4'b1110, 0, RS, 0, 5, RS, 32'h0, 0);
        add(4'b1110, 1, RP, 32'h1, 1, RP, 32'h1, 1);
        add(4'b1110, 0, RS, 0, 0, RS, 32'h1, 1);
        add(4'b1110, 0, RS, 0, 0, RC, 32'h3, 1);
        add(4'b1110, 1, RP, 32'hF, 1, RP, 32'h0, 0);
        add(4'b1111, 0, RS, 0, 6, RS, 32'h0, 0);
        add_stop();
        // All four together from a preloaded count of 0xFFFE
        add(4'b0000, 0, RS, 0, 5, RC, 32'hFFFE, 0);
        add(4'b0000, 0, RS, 0, 1, RC, 32'h0002, 1);
        add(4'b0000, 0, RS, 0, 0, RS, 32'hF, 1);
        add(4'b0000, 0, RS, 0, 0, RP, 32'hF, 1);
        add(4'b0000, 1, RC, 32'h1234, 1, RC, 32'h0, 1);
        add(4'b0000, 1, RP, 32'hF, 1, RP, 32'h0, 0);
        add(4'b1111, 0, RS, 0, 6, RS, 32'h0, 0);
        add(4'b1111, 0, RS, 0, 0, RC, 32'h0, 0);
        add_stop();

        rst     = 1'b1;
        user_pb = 4'b1111;
        ADD_I   = RS;
        WE_I    = 1'b0;
        DAT_I   = '0;
        tick();
        tick();
        rst = 1'b0;
        run_vecs();

        // Clean press of button 1: stable exactly 6 cycles after the raw edge
        user_pb = 4'b1110;
        for (int c = 0; c < 5; c++) tick();
        chk_reg("press_state_5cyc", RS, 32'h0);
        chk_reg("press_pend_5cyc", RP, 32'h0);
        tick();
        chk_reg("press_state_6cyc", RS, 32'h1);
        cmp("press_irq_masked", {31'b0, IRQ}, 32'h0);
        run_vecs();

        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        chk_reg("count_preload", RC, 32'hFFFE);
        run_vecs();

        // Reset two cycles into a press aborts it; press restarts after reset
        user_pb = 4'b1110;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_reg("rst_mid_state", RS, 32'h0);
        chk_reg("rst_mid_pend", RP, 32'h0);
        chk_reg("rst_mid_count", RC, 32'h0);
        chk_reg("rst_mid_mask", RM, 32'h0);
        cmp("rst_mid_irq", {31'b0, IRQ}, 32'h0);
        for (int c = 0; c < 5; c++) tick();
        chk_reg("rst_after_5cyc", RS, 32'h0);
        tick();
        chk_reg("rst_after_6cyc", RS, 32'h1);
        chk_reg("rst_after_pend", RP, 32'h1);
        chk_reg("rst_after_count", RC, 32'h1);
        cmp("rst_after_irq", {31'b0, IRQ}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
